fifo_stat_regs: RTL and testbench

Parametrised, multi-channel FIFO status register window for the 0x4000_0400 peripheral slot, superseding the fixed two-FIFO status window. Beyond live count and empty/full, each channel has a peak-occupancy (high-water) tracker, a programmable threshold, and sticky overflow, underflow and threshold flags. An optional masked, registered interrupt summarises the sticky flags. The block sits on the same simple request bus as the other register windows and observes per-channel FIFO count and push/pop strobes.

---
 rtl/fifo_stat_regs.sv | 143 ++++++++++++++
 tb/tb_fifo_stat_regs.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stat_regs.sv
// Multi-channel FIFO status window: live count/empty/full, sticky OVF/UNF/THR, peak and threshold.
// Define FIFO_STAT_IRQ_EN to implement IRQ_EN (0x80), IRQ_PEND (0x84) and the registered irq.
module fifo_stat_regs #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  input  logic [3:0]              req_wstrb,
  output logic [31:0]             rdata,
  input  logic [NUM_CH*CNT_W-1:0] fifo_count,
  input  logic [NUM_CH-1:0]       fifo_empty,
  input  logic [NUM_CH-1:0]       fifo_full,
  input  logic [NUM_CH-1:0]       fifo_push,
  input  logic [NUM_CH-1:0]       fifo_pop,
  output logic                    irq
);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt, peak_q, peak_d, thresh_q, thresh_d;
  logic [NUM_CH-1:0]            ovf_q, ovf_d, unf_q, unf_d, thr_q, thr_d, thr_hit, pend;
  logic [NUM_CH-1:0]            ch_wr, stat_wr, peak_wr, thresh_wr;
  logic [7:0]                   addr;
  logic [2:0]                   ch_sel;
  logic [1:0]                   reg_sel;
  logic                         wr, ch_hit;
  logic [CNT_W-1:0]             tmask;
  logic [31:0]                  glob_rdata;
  logic                         unused_bus;

  assign addr    = req_addr[7:0];
  assign ch_sel  = addr[6:4];
  assign reg_sel = addr[3:2];
  assign wr      = req_valid & req_write;
  assign ch_hit  = ~addr[7] & (addr[1:0] == 2'b00) & ({29'd0, ch_sel} < NUM_CH);
  assign cnt     = fifo_count;

  assign unused_bus = ^{req_addr, req_wdata, req_wstrb};

  always_comb begin
    ch_wr = '0;
    for (int c = 0; c < NUM_CH; c++) ch_wr[c] = wr & ch_hit & (ch_sel == 3'(c));
  end

  assign stat_wr   = ch_wr & {NUM_CH{(reg_sel == 2'd1) & req_wstrb[0]}};
  assign peak_wr   = ch_wr & {NUM_CH{(reg_sel == 2'd2) & req_wstrb[0]}};
  assign thresh_wr = ch_wr & {NUM_CH{reg_sel == 2'd3}};

  // Set terms are OR-ed after the W1C mask so a simultaneous set wins.
  assign ovf_d = (ovf_q & ~(stat_wr & {NUM_CH{req_wdata[2]}})) | (fifo_push & fifo_full);
  assign unf_d = (unf_q & ~(stat_wr & {NUM_CH{req_wdata[3]}})) | (fifo_pop & fifo_empty);
  assign thr_d = (thr_q & ~(stat_wr & {NUM_CH{req_wdata[4]}})) | thr_hit;
  assign pend  = ovf_q | unf_q | thr_q;

  always_comb begin
    tmask = '0;
    for (int b = 0; b < CNT_W; b++) tmask[b] = (b < 8) ? req_wstrb[0] : req_wstrb[1];
  end

  always_comb begin
    peak_d   = peak_q;
    thresh_d = thresh_q;
    thr_hit  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      thr_hit[c] = (thresh_q[c] != '0) && (cnt[c] >= thresh_q[c]);
      if (peak_wr[c] || (cnt[c] > peak_q[c])) peak_d[c] = cnt[c];
      if (thresh_wr[c]) begin
        thresh_d[c] = (thresh_q[c] & ~tmask) | (req_wdata[CNT_W-1:0] & tmask);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q    <= '0;
      unf_q    <= '0;
      thr_q    <= '0;
      peak_q   <= '0;
      thresh_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      thr_q    <= thr_d;
      peak_q   <= peak_d;
      thresh_q <= thresh_d;
    end
  end

  always_comb begin
    rdata = glob_rdata;
    if (ch_hit) begin
      rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 3'(c)) begin
          case (reg_sel)
            2'd0:    rdata = 32'(cnt[c]);
            2'd1:    rdata = {27'd0, thr_q[c], unf_q[c], ovf_q[c], fifo_full[c], fifo_empty[c]};
            2'd2:    rdata = 32'(peak_q[c]);
            default: rdata = 32'(thresh_q[c]);
          endcase
        end
      end
    end
  end

`ifdef FIFO_STAT_IRQ_EN
  logic [NUM_CH-1:0] irq_en_q, irq_en_d;
  logic              irq_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr && (addr == 8'h80) && req_wstrb[0]) irq_en_d = req_wdata[NUM_CH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= |(irq_en_q & pend);
    end
  end

  always_comb begin
    glob_rdata = '0;
    if (addr == 8'h80)      glob_rdata = 32'(irq_en_q);
    else if (addr == 8'h84) glob_rdata = 32'(pend);
  end

  assign irq = irq_q;
`else
  logic unused_pend;

  assign unused_pend = ^pend;
  assign glob_rdata  = '0;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stat_regs.sv
// Bench for fifo_stat_regs: directed scenarios plus randomized traffic against a register-level
// model; interrupt expectations follow whether FIFO_STAT_IRQ_EN is defined.
module tb_fifo_stat_regs;
  localparam int NCH = 2;
  localparam int CW  = 10;
`ifdef FIFO_STAT_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_write;
  logic [31:0]       req_addr, req_wdata;
  logic [3:0]        req_wstrb;
  logic [31:0]       rdata;
  logic [NCH*CW-1:0] fifo_count;
  logic [NCH-1:0]    fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic              irq;

  int vectors = 0;
  int miscompares = 0;

  int       m_peak[NCH];
  int       m_thr[NCH];
  bit       m_ovf[NCH];
  bit       m_unf[NCH];
  bit       m_thf[NCH];
  logic [NCH-1:0] m_en;
  logic     m_irq;

  logic [31:0] addrs[14] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                             32'h24, 32'h3C, 32'h80, 32'h84, 32'h90, 32'h4000_0414};

  fifo_stat_regs #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rdata      (rdata),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_push  (fifo_push),
    .fifo_pop   (fifo_pop),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ch_cnt(int c);
    return int'(fifo_count[c*CW +: CW]);
  endfunction

  function automatic logic [NCH-1:0] m_pend();
    logic [NCH-1:0] p = '0;
    for (int c = 0; c < NCH; c++) p[c] = m_ovf[c] | m_unf[c] | m_thf[c];
    return p;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr);
    int a = int'(addr[7:0]);
    int c = a / 16;
    if (a < 'h80 && a % 4 == 0 && c < NCH) begin
      case (a % 16)
        0:       return 32'(ch_cnt(c));
        4:       return {27'd0, m_thf[c], m_unf[c], m_ovf[c], fifo_full[c], fifo_empty[c]};
        8:       return 32'(m_peak[c]);
        default: return 32'(m_thr[c]);
      endcase
    end
    if (IrqOn && a == 'h80) return 32'(m_en);
    if (IrqOn && a == 'h84) return 32'(m_pend());
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_peak[c] = 0; m_thr[c] = 0; m_ovf[c] = 0; m_unf[c] = 0; m_thf[c] = 0;
    end
    m_en  = '0;
    m_irq = 1'b0;
  endtask

  // Advance one clock, predicting every register from the values presented before the edge.
  task automatic clk_step();
    int n_peak[NCH];
    int n_thr[NCH];
    bit n_ovf[NCH];
    bit n_unf[NCH];
    bit n_thf[NCH];
    logic [NCH-1:0] n_en = m_en;
    logic n_irq = IrqOn && ((m_en & m_pend()) != '0);
    bit wr = req_valid && req_write;
    int a = int'(req_addr[7:0]);
    int wmask = (req_wstrb[0] ? 'hFF : 0) | (req_wstrb[1] ? 'hFF00 : 0);
    for (int c = 0; c < NCH; c++) begin
      int  cnt = ch_cnt(c);
      bit  on = wr && a < 'h80 && a % 4 == 0 && a / 16 == c;
      bit  sclr = on && a % 16 == 4 && req_wstrb[0];
      n_ovf[c] = (fifo_push[c] && fifo_full[c]) || (m_ovf[c] && !(sclr && req_wdata[2]));
      n_unf[c] = (fifo_pop[c] && fifo_empty[c]) || (m_unf[c] && !(sclr && req_wdata[3]));
      n_thf[c] = (m_thr[c] != 0 && cnt >= m_thr[c]) || (m_thf[c] && !(sclr && req_wdata[4]));
      n_peak[c] = (on && a % 16 == 8 && req_wstrb[0]) ? cnt :
                  ((cnt > m_peak[c]) ? cnt : m_peak[c]);
      n_thr[c] = (on && a % 16 == 12) ?
                 (((m_thr[c] & ~wmask) | (int'(req_wdata[15:0]) & wmask)) & ((1 << CW) - 1)) :
                 m_thr[c];
    end
    if (IrqOn && wr && a == 'h80 && req_wstrb[0]) n_en = req_wdata[NCH-1:0];
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      m_peak[c] = n_peak[c]; m_thr[c] = n_thr[c];
      m_ovf[c] = n_ovf[c]; m_unf[c] = n_unf[c]; m_thf[c] = n_thf[c];
    end
    m_en  = n_en;
    m_irq = n_irq;
  endtask

  task automatic bus_write(logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    req_valid = 1'b1; req_write = 1'b1;
    req_addr = addr; req_wdata = data; req_wstrb = strb;
    clk_step();
    req_valid = 1'b0; req_write = 1'b0; req_wstrb = 4'h0;
  endtask

  task automatic expect_rd(string tag, logic [31:0] addr, logic [31:0] exp);
    req_addr = addr;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic model_rd(string tag, logic [31:0] addr);
    req_addr = addr;
    #1;
    check(tag, rdata, model_read(addr));
  endtask

  task automatic set_cnt(int c, int v);
    fifo_count[c*CW +: CW] = CW'(v);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    fifo_count = '0; fifo_empty = '1; fifo_full = '0; fifo_push = '0; fifo_pop = '0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state: everything reads 0 except live empty in STATUS.
    for (int a = 0; a < 'hA0; a += 4) begin
      expect_rd("reset_rd", 32'(a), (a == 'h04 || a == 'h14) ? 32'h1 : 32'h0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);

    // Peak tracking and reload.
    fifo_empty = 2'b00;
    set_cnt(0, 300); clk_step();
    set_cnt(0, 120); clk_step();
    expect_rd("peak_300", 32'h08, 32'd300);
    bus_write(32'h08, 32'h0, 4'h1);
    expect_rd("peak_clr", 32'h08, 32'd120);
    set_cnt(0, 130); clk_step();
    expect_rd("peak_130", 32'h08, 32'd130);

    // Overflow sticky, W1C, and set-beats-clear.
    fifo_full[1] = 1'b1; fifo_push[1] = 1'b1;
    clk_step();
    fifo_push = '0;
    expect_rd("ovf_set", 32'h14, 32'h6);
    bus_write(32'h14, 32'h4, 4'h1);
    expect_rd("ovf_w1c", 32'h14, 32'h2);
    fifo_push[1] = 1'b1;
    bus_write(32'h14, 32'h4, 4'h1);
    fifo_push = '0;
    expect_rd("ovf_race", 32'h14, 32'h6);
    bus_write(32'h14, 32'h4, 4'h1);
    fifo_full[1] = 1'b0;
    expect_rd("ovf_clr2", 32'h14, 32'h0);

    // Underflow sticky.
    fifo_empty[0] = 1'b1; fifo_pop[0] = 1'b1;
    clk_step();
    fifo_pop = '0;
    expect_rd("unf_set", 32'h04, 32'h9);
    bus_write(32'h04, 32'h8, 4'h1);
    fifo_empty[0] = 1'b0;
    expect_rd("unf_w1c", 32'h04, 32'h0);

    // Threshold and interrupt timing.
    bus_write(32'h0C, 32'd200, 4'h3);
    bus_write(32'h80, 32'h1, 4'h1);
    set_cnt(0, 199); clk_step();
    expect_rd("thr_199", 32'h04, 32'h0);
    set_cnt(0, 200); clk_step();
    expect_rd("thr_200", 32'h04, 32'h10);
    check("irq_1clk", {31'd0, irq}, 32'd0);
    clk_step();
    check("irq_2clk", {31'd0, irq}, 32'(IrqOn));
    expect_rd("irq_pend", 32'h84, 32'(IrqOn));
    expect_rd("irq_en", 32'h80, 32'(IrqOn));
    bus_write(32'h04, 32'h10, 4'h1);
    expect_rd("thr_reset", 32'h04, 32'h10);
    check("irq_hold", {31'd0, irq}, 32'(IrqOn));
    bus_write(32'h0C, 32'h0, 4'h3);
    bus_write(32'h04, 32'h10, 4'h1);
    expect_rd("thr_clr", 32'h04, 32'h0);
    check("irq_lag", {31'd0, irq}, 32'(IrqOn));
    clk_step();
    check("irq_drop", {31'd0, irq}, 32'd0);

    // Partial/masked writes and ignored regions.
    bus_write(32'h1C, 32'h0000_0300, 4'h2);
    expect_rd("thr1_hi", 32'h1C, 32'h300);
    bus_write(32'h1C, 32'hFFFF_FFFF, 4'hF);
    expect_rd("thr1_mask", 32'h1C, 32'h3FF);
    bus_write(32'h3C, 32'hFFFF_FFFF, 4'hF);
    expect_rd("ch3_rd", 32'h3C, 32'h0);
    bus_write(32'h90, 32'hFFFF_FFFF, 4'hF);
    expect_rd("undef_rd", 32'h90, 32'h0);
    expect_rd("thr1_keep", 32'h1C, 32'h3FF);
    expect_rd("thr0_keep", 32'h0C, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) set_cnt(c, $urandom_range(0, 1023));
      fifo_push  = NCH'($urandom);
      fifo_pop   = NCH'($urandom);
      fifo_full  = NCH'($urandom);
      fifo_empty = NCH'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1'b1; req_write = 1'b1;
        req_addr  = addrs[$urandom_range(0, 13)];
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
      end
      clk_step();
      req_valid = 1'b0; req_write = 1'b0;
      fifo_push = '0; fifo_pop = '0;
      model_rd("rand_rd", addrs[$urandom_range(0, 13)]);
      check("rand_irq", {31'd0, irq}, {31'd0, m_irq});
    end

    // Asynchronous reset mid-cycle.
    set_cnt(0, 77);
    clk_step();
    rst_n = 1'b0;
    #1;
    model_reset();
    expect_rd("arst_peak", 32'h08, 32'h0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    clk_step();
    model_rd("post_rst_peak", 32'h08);
    model_rd("post_rst_stat", 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
